// File: rtl/uart_pkg.sv
// Types and constants shared by the UART transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and 3-sample majority vote around mid-bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  active_i,
  input  logic                  start_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  rx_i,
  output logic                  sampled_bit_o,
  output logic                  bit_end_o
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO = PRESCALE_W'(2);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [PRESCALE_W-1:0] mid_s, last_s;
  logic [2:0]            samp_q, samp_d;
  logic                  sampled_q, sampled_d;

  assign mid_s         = prescale_i >> 1;
  assign last_s        = prescale_i - ONE;
  assign bit_end_o     = active_i && (edge_cnt_q == last_s);
  assign sampled_bit_o = sampled_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    samp_d     = samp_q;
    sampled_d  = sampled_q;
    // Start detection already consumed tick 0, so the counter resumes at 1.
    if (start_i) begin
      edge_cnt_d = ONE;
    end else if (active_i) begin
      if (edge_cnt_q == last_s) begin
        edge_cnt_d = '0;
      end else begin
        edge_cnt_d = edge_cnt_q + ONE;
      end
    end else begin
      edge_cnt_d = '0;
    end
    if (active_i) begin
      if (edge_cnt_q == mid_s - ONE) begin
        samp_d[0] = rx_i;
      end else if (edge_cnt_q == mid_s) begin
        samp_d[1] = rx_i;
      end else if (edge_cnt_q == mid_s + ONE) begin
        samp_d[2] = rx_i;
      end else if (edge_cnt_q == mid_s + TWO) begin
        sampled_d = majority3(samp_q[0], samp_q[1], samp_q[2]);
      end else begin
        sampled_d = sampled_q;
      end
    end else begin
      samp_d = samp_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt_q <= '0;
      samp_q     <= 3'b111;
      sampled_q  <= 1'b1;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
      sampled_q  <= sampled_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, data shift register, parity/stop checks, registered strobes.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_fail_q, par_fail_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  start_s, active_s, sampled_bit_s, bit_end_s, exp_par_s;

  assign start_s   = (state_q == IDLE) && !RX_IN;
  assign active_s  = (state_q != IDLE);
  assign exp_par_s = (par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_sampler (
    .CLK           (CLK),
    .RST           (RST),
    .active_i      (active_s),
    .start_i       (start_s),
    .prescale_i    (presc_q),
    .rx_i          (RX_IN),
    .sampled_bit_o (sampled_bit_s),
    .bit_end_o     (bit_end_s)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_fail_d = par_fail_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    presc_d    = presc_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // Frame configuration is frozen here; mid-frame changes are ignored.
        if (!RX_IN) begin
          state_d    = START;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          presc_d    = Prescale;
          par_fail_d = 1'b0;
          bit_cnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = sampled_bit_s ? IDLE : DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_d[bit_cnt_q] = sampled_bit_s;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          par_fail_d = (sampled_bit_s != exp_par_s);
          state_d    = STOP;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          state_d   = IDLE;
          stp_err_d = !sampled_bit_s;
          par_err_d = par_fail_q;
          if (sampled_bit_s && !par_fail_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            data_d = data_q;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_fail_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      presc_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_fail_q <= par_fail_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      presc_q    <= presc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign P_DATA     = data_q;
  assign data_valid = valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: drives serial frames and counts output strobes.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic       clr_req = 1'b0;
  int         cyc = 0;
  int         v_cnt = 0;
  int         p_cnt = 0;
  int         s_cnt = 0;
  logic [7:0] v_data[$];
  int         v_cyc[$];

  uart_rx dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 CLK = ~CLK;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge CLK) begin
    cyc++;
    if (clr_req) begin
      v_cnt = 0;
      p_cnt = 0;
      s_cnt = 0;
      v_data.delete();
      v_cyc.delete();
    end else begin
      if (data_valid) begin
        v_cnt++;
        v_data.push_back(P_DATA);
        v_cyc.push_back(cyc);
      end
      if (par_err) p_cnt++;
      if (stp_err) s_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    clr_req = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    clr_req = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int n);
    RX_IN = b;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input logic pe,
                            input logic pbit, input logic stp);
    send_bit(1'b0, n);
    for (int i = 0; i < 8; i++) send_bit(d[i], n);
    if (pe) send_bit(pbit, n);
    send_bit(stp, n);
    RX_IN = 1'b1;
  endtask

  initial begin
    logic [7:0] b0, b1, b2;
    int         gap0, gap1;
    logic [7:0] v77;

    RST      = 1'b1;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_pdata", P_DATA, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_parerr", par_err, 1'b0);
    chk("rst_stperr", stp_err, 1'b0);
    idle(4);

    // 0xA5, even parity (4 ones -> parity bit 0), Prescale 8
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clear_counts();
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
    idle(4);
    chk("a5_valid_cnt", v_cnt, 1);
    chk("a5_pdata", P_DATA, 8'hA5);
    chk("a5_par_cnt", p_cnt, 0);
    chk("a5_stp_cnt", s_cnt, 0);

    // 0x3C odd parity needs bit 1; send 0 -> parity error
    Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    clear_counts();
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
    idle(4);
    chk("3c_par_cnt", p_cnt, 1);
    chk("3c_valid_cnt", v_cnt, 0);
    chk("3c_stp_cnt", s_cnt, 0);
    chk("3c_pdata_hold", P_DATA, 8'hA5);

    // 0x81 no parity, stop bit low -> stop error
    Prescale = 6'd32; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    clear_counts();
    send_frame(8'h81, 32, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("81_stp_cnt", s_cnt, 1);
    chk("81_valid_cnt", v_cnt, 0);
    chk("81_par_cnt", p_cnt, 0);
    chk("81_pdata_hold", P_DATA, 8'hA5);

    // Start glitch of 2 clocks, then clean 0x5A
    Prescale = 6'd8; PAR_EN = 1'b0;
    clear_counts();
    send_bit(1'b0, 2);
    idle(20);
    chk("glitch_valid_cnt", v_cnt, 0);
    chk("glitch_par_cnt", p_cnt, 0);
    chk("glitch_stp_cnt", s_cnt, 0);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("5a_valid_cnt", v_cnt, 1);
    chk("5a_pdata", P_DATA, 8'h5A);

    // Back-to-back 0x00, 0xFF, 0x55 with even parity (all parity bits 0)
    Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clear_counts();
    send_frame(8'h00, 8, 1'b1, 1'b0, 1'b1);
    send_frame(8'hFF, 8, 1'b1, 1'b0, 1'b1);
    send_frame(8'h55, 8, 1'b1, 1'b0, 1'b1);
    idle(4);
    chk("b2b_valid_cnt", v_cnt, 3);
    b0   = (v_data.size() > 0) ? v_data[0] : 8'hEE;
    b1   = (v_data.size() > 1) ? v_data[1] : 8'hEE;
    b2   = (v_data.size() > 2) ? v_data[2] : 8'hEE;
    gap0 = (v_cyc.size() > 1) ? v_cyc[1] - v_cyc[0] : -1;
    gap1 = (v_cyc.size() > 2) ? v_cyc[2] - v_cyc[1] : -1;
    chk("b2b_byte0", b0, 8'h00);
    chk("b2b_byte1", b1, 8'hFF);
    chk("b2b_byte2", b2, 8'h55);
    chk("b2b_gap0", gap0, 88);
    chk("b2b_gap1", gap1, 88);
    chk("b2b_err_cnt", p_cnt + s_cnt, 0);

    // Reset in the middle of 0x77's data bits, then a clean 0x12
    Prescale = 6'd8; PAR_EN = 1'b0;
    clear_counts();
    v77 = 8'h77;
    send_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) send_bit(v77[i], 8);
    send_bit(v77[3], 4);
    RST   = 1'b1;
    RX_IN = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(30);
    chk("rst77_valid_cnt", v_cnt, 0);
    chk("rst77_err_cnt", p_cnt + s_cnt, 0);
    chk("rst77_pdata", P_DATA, 8'h00);
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1);
    idle(4);
    chk("12_valid_cnt", v_cnt, 1);
    chk("12_pdata", P_DATA, 8'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
